random_engine_sched: RTL and testbench
======================================

RANDOM_ENGINE_SCHED -- requirements
Module: random_engine_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of LFSR channels controlled.
REQ-002 SHALL have parameter CNT_W, default 16: width of burst length and enable counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have port start, input, 1: request to begin a run; sampled in IDLE only.
REQ-006 SHALL have port stop, input, 1: abort request; sampled in SEED and RUN.
REQ-007 SHALL have port mode, input, 2: 00 CONT, 01 BURST, 10 STEP, 11 reserved; captured on start accept.
REQ-008 SHALL have port burst_len, input, CNT_W: number of enable cycles in BURST; captured on start accept.
REQ-009 SHALL have port ch_mask, input, NUM_CH: channels participating; captured on start accept.
REQ-010 SHALL have port reseed, input, 1: when 1 at start accept, a SEED cycle precedes RUN.
REQ-011 SHALL have port active, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have port lfsr_en, output, NUM_CH: per-channel LFSR step enable to datapath.
REQ-013 SHALL have port seed_load, output, NUM_CH: per-channel seed load strobe to datapath.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on normal completion of BURST or STEP.
REQ-015 SHALL have port count, output, CNT_W: number of enable cycles issued in current/last run.

Function
REQ-016 SHALL implement states IDLE, SEED, RUN.
REQ-017 Start accept SHALL occur in IDLE when start=1, mode!=11, ch_mask!=0, and (mode!=BURST or burst_len!=0); otherwise start is ignored and state remains IDLE.
REQ-018 On start accept SHALL capture mode, burst_len, ch_mask into registers, clear count to 0, and move to SEED if reseed=1 else RUN.
REQ-019 SEED SHALL last exactly one cycle, drive seed_load = captured mask, lfsr_en = 0; next state RUN, or IDLE if stop=1.
REQ-020 seed_load SHALL be 0 in all states other than SEED.
REQ-021 In RUN, lfsr_en SHALL equal captured mask when stop=0 and all-zero when stop=1 (combinational on stop, as lfsr_en = mask AND NOT stop).
REQ-022 lfsr_en SHALL be all-zero in IDLE and SEED; first enable is the first RUN cycle (1 cycle after accept without reseed, 2 with reseed).
REQ-023 count SHALL increment by 1 in every RUN cycle with lfsr_en nonzero; in CONT it SHALL saturate at all-ones.
REQ-024 CONT: RUN SHALL persist until stop=1, then return to IDLE next cycle; done not asserted.
REQ-025 BURST: RUN cycle in which count == captured burst_len-1 and stop=0 is the last; next state IDLE, done=1 in the following (first IDLE) cycle.
REQ-026 STEP: RUN SHALL last exactly one cycle; with stop=0 the single enable is issued and done pulses next cycle.
REQ-027 stop in RUN SHALL take priority over burst/step completion: no enable that cycle, next state IDLE, done=0.
REQ-028 done SHALL be registered and high for exactly one cycle per completion; a start in that same IDLE cycle SHALL be accepted normally.
REQ-029 count SHALL hold its final value in IDLE until the next start accept.
REQ-030 Inputs mode, burst_len, ch_mask, reseed SHALL have no effect outside the accept cycle.

Reset
REQ-031 With rst=0 at a clock edge, state SHALL become IDLE, count 0, done 0, captured registers 0, overriding any in-progress run.
REQ-032 During and after reset: active=0, lfsr_en=0, seed_load=0, done=0.

Structure
REQ-033 Package random_engine_pkg SHALL hold state encoding and mode encodings (CONT, BURST, STEP, reserved).
REQ-034 State, capture and counter flops SHALL use the existing Register module (parametrised width, enable, reset) as the single sub-module.

Verification
REQ-035 CONT: NUM_CH=4, start, mask=1011, reseed=0, stop after 5 RUN cycles -> lfsr_en=1011 for 5 cycles, count=5, done never high.
REQ-036 BURST: burst_len=3, reseed=1 -> seed_load=mask 1 cycle, lfsr_en 3 cycles, done pulse next cycle, count=3, active high 4 cycles.
REQ-037 STEP twice back-to-back with start held -> one enable, done, then second accept in done cycle, count=1 each run.
REQ-038 Rejects: mode=11, mask=0000, or BURST with burst_len=0 -> state stays IDLE, active=0, no enables.
REQ-039 BURST burst_len=10, stop at 4th RUN cycle -> 3 enables, no enable that cycle, IDLE next, done=0, count=3.
REQ-040 rst=0 mid-BURST -> next cycle active=0, lfsr_en=0, count=0, done=0.

Source files
------------

// File: rtl/random_engine_pkg.sv
// Shared encodings for the random engine scheduler: FSM states and run modes.
package random_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONT  = 2'd0,
    MODE_BURST = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // A mode value is usable for a run unless it is the reserved encoding.
  function automatic logic mode_valid(input logic [1:0] m);
    return m != MODE_RSVD;
  endfunction

endpackage

// File: rtl/random_engine_sched_register.sv
// Generic enabled register with synchronous active-low reset to zero.
module random_engine_sched_register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/random_engine_sched.sv
// Run scheduler for a bank of LFSR channels: IDLE -> (SEED) -> RUN -> IDLE,
// with continuous, fixed-length burst and single-step modes.
module random_engine_sched
  import random_engine_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              reseed,
  output logic              active,
  output logic [NUM_CH-1:0] lfsr_en,
  output logic [NUM_CH-1:0] seed_load,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  len_q;
  logic [NUM_CH-1:0] mask_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;

  logic accept;
  logic in_run;
  logic in_seed;
  logic run_step;
  logic count_en;

  assign in_run   = (state_q == ST_RUN);
  assign in_seed  = (state_q == ST_SEED);
  // An enable is issued in every RUN cycle unless stop cancels it.
  assign run_step = in_run && !stop;

  // Start is only honoured in IDLE with a legal, non-empty configuration.
  always_comb begin
    accept = 1'b0;
    if ((state_q == ST_IDLE) && start && mode_valid(mode) && (ch_mask != '0)
        && ((mode != MODE_BURST) || (burst_len != '0))) begin
      accept = 1'b1;
    end
  end

  // Next state, count and completion pulse.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    count_en = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = reseed ? ST_SEED : ST_RUN;
          count_d  = '0;
          count_en = 1'b1;
        end
      end
      ST_SEED: begin
        state_d = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          // Abort wins over any completion this cycle.
          state_d = ST_IDLE;
        end else begin
          count_en = 1'b1;
          // Saturation only matters in CONT; finite modes end before wrap.
          count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
          if (mode_q == MODE_STEP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if ((mode_q == MODE_BURST) && (count_q == len_q - CNT_ONE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  random_engine_sched_register #(.W(2)) u_state_reg (
    .clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_q)
  );

  random_engine_sched_register #(.W(2)) u_mode_reg (
    .clk(clk), .rst(rst), .en(accept), .d(mode), .q(mode_q)
  );

  random_engine_sched_register #(.W(CNT_W)) u_len_reg (
    .clk(clk), .rst(rst), .en(accept), .d(burst_len), .q(len_q)
  );

  random_engine_sched_register #(.W(NUM_CH)) u_mask_reg (
    .clk(clk), .rst(rst), .en(accept), .d(ch_mask), .q(mask_q)
  );

  random_engine_sched_register #(.W(CNT_W)) u_count_reg (
    .clk(clk), .rst(rst), .en(count_en), .d(count_d), .q(count_q)
  );

  random_engine_sched_register #(.W(1)) u_done_reg (
    .clk(clk), .rst(rst), .en(1'b1), .d(done_d), .q(done_q)
  );

  // Per-channel strobes; rst gating keeps outputs quiet while reset is held.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign lfsr_en[gi]   = rst && run_step && mask_q[gi];
    assign seed_load[gi] = rst && in_seed && mask_q[gi];
  end

  assign active = rst && (state_q != ST_IDLE);
  assign done   = rst && done_q;
  assign count  = count_q;

endmodule

// File: tb/tb_random_engine_sched.sv
// Directed bench for random_engine_sched (NUM_CH=4, CNT_W=16).
module tb_random_engine_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] burst_len;
  logic [3:0]  ch_mask;
  logic        reseed;
  logic        active;
  logic [3:0]  lfsr_en;
  logic [3:0]  seed_load;
  logic        done;
  logic [15:0] count;

  int tests_run;
  int tests_failed;

  random_engine_sched #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .ch_mask(ch_mask), .reseed(reseed),
    .active(active), .lfsr_en(lfsr_en), .seed_load(seed_load),
    .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
    burst_len = 16'd0; ch_mask = 4'b0000; reseed = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    tests_run++;
    if (active !== 1'b0 || lfsr_en !== 4'b0 || seed_load !== 4'b0 || done !== 1'b0 || count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: active=%b lfsr_en=%b seed_load=%b done=%b count=%0d, want 0 0000 0000 0 0",
               active, lfsr_en, seed_load, done, count);
    end
    $display("[TB] reset: active=%b count=%0d", active, count);
  endtask

  task automatic test_cont();
    start = 1'b1; mode = 2'b00; ch_mask = 4'b1011; reseed = 1'b0;
    cyc();
    // Changing capture inputs after accept must not matter.
    start = 1'b0; ch_mask = 4'b0000; mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (lfsr_en !== 4'b1011 || active !== 1'b1 || done !== 1'b0 || count !== 16'(i)) begin
        tests_failed++;
        $display("FAIL cont_run%0d: lfsr_en=%b active=%b done=%b count=%0d, want 1011 1 0 %0d",
                 i, lfsr_en, active, done, count, i);
      end
      cyc();
    end
    stop = 1'b1;
    #1;
    tests_run++;
    if (lfsr_en !== 4'b0000 || count !== 16'd5) begin
      tests_failed++;
      $display("FAIL cont_stop: lfsr_en=%b count=%0d, want 0000 5", lfsr_en, count);
    end
    cyc();
    stop = 1'b0;
    #1;
    tests_run++;
    if (active !== 1'b0 || done !== 1'b0 || count !== 16'd5) begin
      tests_failed++;
      $display("FAIL cont_idle: active=%b done=%b count=%0d, want 0 0 5", active, done, count);
    end
    $display("[TB] cont: count=%0d", count);
  endtask

  task automatic test_burst_reseed();
    start = 1'b1; mode = 2'b01; burst_len = 16'd3; ch_mask = 4'b0110; reseed = 1'b1;
    cyc();
    start = 1'b0; reseed = 1'b0; burst_len = 16'd9;
    #1;
    tests_run++;
    if (seed_load !== 4'b0110 || lfsr_en !== 4'b0000 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_seed: seed_load=%b lfsr_en=%b active=%b, want 0110 0000 1", seed_load, lfsr_en, active);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (lfsr_en !== 4'b0110 || seed_load !== 4'b0000 || active !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL burst_run%0d: lfsr_en=%b seed_load=%b active=%b done=%b, want 0110 0000 1 0",
                 i, lfsr_en, seed_load, active, done);
      end
      cyc();
    end
    #1;
    tests_run++;
    if (done !== 1'b1 || active !== 1'b0 || count !== 16'd3 || lfsr_en !== 4'b0000) begin
      tests_failed++;
      $display("FAIL burst_done: done=%b active=%b count=%0d lfsr_en=%b, want 1 0 3 0000", done, active, count, lfsr_en);
    end
    cyc();
    tests_run++;
    if (done !== 1'b0 || count !== 16'd3) begin
      tests_failed++;
      $display("FAIL burst_done_once: done=%b count=%0d, want 0 3", done, count);
    end
    $display("[TB] burst: count=%0d", count);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 2'b10; ch_mask = 4'b0001; reseed = 1'b0;
    cyc();
    #1;
    tests_run++;
    if (lfsr_en !== 4'b0001 || count !== 16'd0) begin
      tests_failed++;
      $display("FAIL step1_run: lfsr_en=%b count=%0d, want 0001 0", lfsr_en, count);
    end
    cyc();
    tests_run++;
    if (done !== 1'b1 || count !== 16'd1 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL step1_done: done=%b count=%0d active=%b, want 1 1 0", done, count, active);
    end
    cyc();
    start = 1'b0;
    #1;
    tests_run++;
    if (lfsr_en !== 4'b0001 || count !== 16'd0 || done !== 1'b0 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL step2_run: lfsr_en=%b count=%0d done=%b active=%b, want 0001 0 0 1", lfsr_en, count, done, active);
    end
    cyc();
    tests_run++;
    if (done !== 1'b1 || count !== 16'd1) begin
      tests_failed++;
      $display("FAIL step2_done: done=%b count=%0d, want 1 1", done, count);
    end
    cyc();
    tests_run++;
    if (done !== 1'b0 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL step2_after: done=%b active=%b, want 0 0", done, active);
    end
    $display("[TB] back_to_back: count=%0d", count);
  endtask

  task automatic test_reject();
    logic [1:0]  r_mode [3];
    logic [3:0]  r_mask [3];
    logic [15:0] r_len  [3];
    r_mode = '{2'b11, 2'b00, 2'b01};
    r_mask = '{4'b1111, 4'b0000, 4'b1111};
    r_len  = '{16'd5, 16'd5, 16'd0};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mode = r_mode[i]; ch_mask = r_mask[i]; burst_len = r_len[i]; reseed = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      tests_run++;
      if (active !== 1'b0 || lfsr_en !== 4'b0000 || seed_load !== 4'b0000 || count !== 16'd1) begin
        tests_failed++;
        $display("FAIL reject%0d: active=%b lfsr_en=%b seed_load=%b count=%0d, want 0 0000 0000 1",
                 i, active, lfsr_en, seed_load, count);
      end
      cyc();
      $display("[TB] reject%0d: active=%b", i, active);
    end
    reseed = 1'b0;
  endtask

  task automatic test_burst_stop();
    start = 1'b1; mode = 2'b01; burst_len = 16'd10; ch_mask = 4'b1111; reseed = 1'b0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (lfsr_en !== 4'b1111) begin
        tests_failed++;
        $display("FAIL bstop_run%0d: lfsr_en=%b, want 1111", i, lfsr_en);
      end
      cyc();
    end
    stop = 1'b1;
    #1;
    tests_run++;
    if (lfsr_en !== 4'b0000 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL bstop_cut: lfsr_en=%b active=%b, want 0000 1", lfsr_en, active);
    end
    cyc();
    stop = 1'b0;
    #1;
    tests_run++;
    if (active !== 1'b0 || done !== 1'b0 || count !== 16'd3) begin
      tests_failed++;
      $display("FAIL bstop_idle: active=%b done=%b count=%0d, want 0 0 3", active, done, count);
    end
    cyc();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL bstop_nodone: done=%b, want 0", done);
    end
    $display("[TB] burst_stop: count=%0d", count);
  endtask

  task automatic test_seed_stop();
    start = 1'b1; mode = 2'b00; ch_mask = 4'b0101; reseed = 1'b1;
    cyc();
    start = 1'b0; reseed = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    tests_run++;
    if (active !== 1'b0 || lfsr_en !== 4'b0000 || count !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL seed_stop: active=%b lfsr_en=%b count=%0d done=%b, want 0 0000 0 0", active, lfsr_en, count, done);
    end
    $display("[TB] seed_stop: active=%b", active);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode = 2'b01; burst_len = 16'd10; ch_mask = 4'b1100; reseed = 1'b0;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    #1;
    tests_run++;
    if (count !== 16'd2 || lfsr_en !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rmid_pre: count=%0d lfsr_en=%b, want 2 1100", count, lfsr_en);
    end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    tests_run++;
    if (active !== 1'b0 || lfsr_en !== 4'b0000 || count !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_post: active=%b lfsr_en=%b count=%0d done=%b, want 0 0000 0 0", active, lfsr_en, count, done);
    end
    cyc();
    tests_run++;
    if (active !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_idle: active=%b done=%b, want 0 0", active, done);
    end
    $display("[TB] reset_mid: count=%0d", count);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_cont();
    test_burst_reseed();
    test_back_to_back();
    test_reject();
    test_burst_stop();
    test_seed_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
